sys_o_wr: RTL and testbench
===========================

SYS_O_WR -- requirements
Module: sys_o_wr

Interface
REQ-001 Parameter FEATURE_BITS, 4, address half-width; wr_addr is 2*FEATURE_BITS wide.
REQ-002 Parameter DATA_W, 16, width of one result word.
REQ-003 Parameter P, 4, systolic result lanes per input beat.
REQ-004 Parameter M, 9, output matrix rows.
REQ-005 Parameter GAMMA, 3, output matrix columns; N = M*GAMMA words per frame, N <= 2^(2*FEATURE_BITS).
REQ-006 sys_clk  in  1  systolic array clock; the only clock.
REQ-007 reset_n  in  1  reset, synchronous, active-low.
REQ-008 frame_start  in  1  one-cycle pulse arming a new frame.
REQ-009 in_valid  in  1  systolic array presents a result beat.
REQ-010 in_data  in  P*DATA_W  result beat; lane k = in_data[k*DATA_W +: DATA_W].
REQ-011 in_ready  out  1  block accepts a beat on this edge when in_valid is high.
REQ-012 wr_en  out  1  sys_out DPR write strobe.
REQ-013 wr_addr  out  2*FEATURE_BITS  sys_out DPR write address.
REQ-014 wr_data  out  DATA_W  sys_out DPR write data.
REQ-015 ag_start  out  1  start level to the downstream sys_out address generator.
REQ-016 ag_done  in  1  completion from the downstream address generator.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, COLLECT, SHIFT, HANDOFF.
REQ-019 IDLE -> COLLECT on frame_start; word counter cleared to 0; frame_start in any other state is ignored.
REQ-020 in_ready SHALL be high in COLLECT, and in SHIFT only while the last lane of a non-final beat is being written; low otherwise.
REQ-021 A beat accepted at edge t SHALL be held in a P-lane register; lane 0 written in cycle t+1, lane k in cycle t+1+k (COLLECT -> SHIFT).
REQ-022 Each write cycle: wr_en=1, wr_addr=word counter, wr_data=current lane; counter increments by 1 per write, range 0..N-1, no wrap.
REQ-023 Beat accepted on the last-lane edge SHALL start its lane 0 in the next cycle: back-to-back beats give gap-free writes.
REQ-024 If no beat accepted at end of a non-final beat, SHIFT -> COLLECT, wr_en=0 until next beat.
REQ-025 Final beat (beat index ceil(N/P)-1) SHALL write only N-(ceil(N/P)-1)*P lanes; extra lanes discarded.
REQ-026 After word N-1 is written, SHIFT -> HANDOFF; ag_start=1 from the next cycle.
REQ-027 ag_start SHALL stay high in HANDOFF until ag_done is sampled high; then HANDOFF -> IDLE, ag_start=0 the following cycle.
REQ-028 in_valid while in_ready is low SHALL be ignored (no data loss responsibility; upstream holds).
REQ-029 ag_done outside HANDOFF SHALL be ignored.

Reset
REQ-030 reset_n low at an edge SHALL force IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, ag_start=0, busy=0, counters and lane register cleared.
REQ-031 Reset mid-frame SHALL abandon the frame; no further writes until a new frame_start.

Structure
REQ-032 Shared package sys_o_pkg SHALL hold the FSM state enum and default values of FEATURE_BITS, DATA_W, P, M, GAMMA.
REQ-033 One sub-module sys_o_ser (P-lane hold register plus lane-select mux and lane counter) is natural; FSM and word counter stay in sys_o_wr.

Verification
REQ-034 Reset: reset_n=0 for 2 cycles with in_valid=1 -> all outputs 0, no wr_en.
REQ-035 Defaults, frame_start then in_valid held high with beats 0..6 -> 27 consecutive wr_en cycles, wr_addr 0..26, last beat lane 3 not written, ag_start rises the cycle after address 26.
REQ-036 Gapped input: in_valid low 3 cycles between beats 2 and 3 -> wr_en low exactly those gap cycles, addresses still contiguous 0..26.
REQ-037 Handoff: ag_done held low 5 cycles then pulsed -> ag_start high 6 cycles, IDLE next, busy=0.
REQ-038 frame_start pulsed mid-SHIFT at address 10 -> ignored, counter continues 11..26.
REQ-039 reset_n=0 one cycle at address 13 -> wr_en=0 next cycle, no writes until new frame_start, new frame restarts at address 0.

Source files
------------

// File: rtl/sys_o_pkg.sv
// Shared definitions for the sys_out write path: FSM state encoding,
// default geometry, and a small width helper.
package sys_o_pkg;

    localparam int FEATURE_BITS_D = 4;
    localparam int DATA_W_D       = 16;
    localparam int P_D            = 4;
    localparam int M_D            = 9;
    localparam int GAMMA_D        = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SHIFT   = 2'd2,
        HANDOFF = 2'd3
    } sys_o_state_e;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int clog2_min1(input int v);
        int w;
        w = 1;
        while ((1 << w) < v) w++;
        return w;
    endfunction

endpackage

// File: rtl/sys_o_wr_if.sv
// Bundle between the systolic result stream, the sys_out DPR write port
// and the downstream address generator handshake.
interface sys_o_wr_if
    import sys_o_pkg::*;
#(
    parameter int FEATURE_BITS = FEATURE_BITS_D,
    parameter int DATA_W       = DATA_W_D,
    parameter int P            = P_D
) ();

    // Beat handshake: a beat transfers on a sys_clk edge where in_valid and
    // in_ready are both high; in_valid while in_ready is low is not consumed.
    logic                      frame_start;
    logic                      in_valid;
    logic [P*DATA_W-1:0]       in_data;
    logic                      in_ready;
    logic                      wr_en;
    logic [2*FEATURE_BITS-1:0] wr_addr;
    logic [DATA_W-1:0]         wr_data;
    logic                      ag_start;
    logic                      ag_done;
    logic                      busy;
    sys_o_state_e              dbg_state;

    modport master (
        input  frame_start, in_valid, in_data, ag_done,
        output in_ready, wr_en, wr_addr, wr_data, ag_start, busy, dbg_state
    );

    modport slave (
        output frame_start, in_valid, in_data, ag_done,
        input  in_ready, wr_en, wr_addr, wr_data, ag_start, busy, dbg_state
    );

endinterface

// File: rtl/sys_o_ser.sv
// P-lane hold register with a lane counter; presents the lane that follows
// the one currently being written.
module sys_o_ser
    import sys_o_pkg::*;
#(
    parameter int DATA_W = DATA_W_D,
    parameter int P      = P_D
) (
    input  logic                sys_clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic                step,
    input  logic [P*DATA_W-1:0] beat,
    output logic                last_lane,
    output logic                next_is_last,
    output logic [DATA_W-1:0]   next_data
);

    localparam int LANE_W = clog2_min1(P);

    logic [P*DATA_W-1:0] hold;
    logic [LANE_W-1:0]   lane;

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            hold <= '0;
            lane <= '0;
        end else if (load) begin
            hold <= beat;
            lane <= '0;
        end else if (step && !last_lane) begin
            lane <= lane + LANE_W'(1);
        end
    end

    assign last_lane    = (int'(lane) == P - 1);
    assign next_is_last = (int'(lane) + 2 == P);

    always_comb begin
        next_data = '0;
        for (int k = 0; k < P; k++) begin
            if (int'(lane) + 1 == k) next_data = hold[k*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/sys_o_wr.sv
// Serialises P-lane systolic result beats into single-word sys_out DPR
// writes, then hands the finished frame to the address generator.
module sys_o_wr
    import sys_o_pkg::*;
#(
    parameter int FEATURE_BITS = FEATURE_BITS_D,
    parameter int DATA_W       = DATA_W_D,
    parameter int P            = P_D,
    parameter int M            = M_D,
    parameter int GAMMA        = GAMMA_D
) (
    input  logic      sys_clk,
    input  logic      reset_n,
    sys_o_wr_if.master bus
);

    localparam int              AW        = 2 * FEATURE_BITS;
    localparam int              N         = M * GAMMA;
    localparam logic [AW-1:0]   LAST_ADDR = AW'(N - 1);

    sys_o_state_e      state;
    logic [AW-1:0]     word_cnt;
    logic              in_ready_q;
    logic              wr_en_q;
    logic [AW-1:0]     wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              ag_start_q;
    logic              busy_q;

    logic              accept;
    logic              last_word;
    logic              step;
    logic              last_lane;
    logic              next_is_last;
    logic [DATA_W-1:0] next_data;

    assign accept    = bus.in_valid && in_ready_q;
    assign last_word = wr_en_q && (wr_addr_q == LAST_ADDR);
    assign step      = (state == SHIFT) && !last_word && !last_lane;

    sys_o_ser #(.DATA_W(DATA_W), .P(P)) u_ser (
        .sys_clk      (sys_clk),
        .reset_n      (reset_n),
        .load         (accept),
        .step         (step),
        .beat         (bus.in_data),
        .last_lane    (last_lane),
        .next_is_last (next_is_last),
        .next_data    (next_data)
    );

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            word_cnt   <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            ag_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.frame_start) begin
                        state      <= COLLECT;
                        word_cnt   <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                COLLECT, SHIFT: begin
                    if (state == SHIFT && last_word) begin
                        state      <= HANDOFF;
                        in_ready_q <= 1'b0;
                        ag_start_q <= 1'b1;
                    end else if (accept) begin
                        // Lane 0 goes straight from the bus; the rest come from the hold register.
                        state      <= SHIFT;
                        wr_en_q    <= 1'b1;
                        wr_addr_q  <= word_cnt;
                        wr_data_q  <= bus.in_data[DATA_W-1:0];
                        word_cnt   <= word_cnt + AW'(1);
                        in_ready_q <= (P == 1) && (word_cnt != LAST_ADDR);
                    end else if (state == SHIFT && last_lane) begin
                        state      <= COLLECT;
                        in_ready_q <= 1'b1;
                    end else if (state == SHIFT) begin
                        wr_en_q    <= 1'b1;
                        wr_addr_q  <= word_cnt;
                        wr_data_q  <= next_data;
                        word_cnt   <= word_cnt + AW'(1);
                        // Open the input only on the last lane of a beat that is not the frame's tail.
                        in_ready_q <= next_is_last && (word_cnt != LAST_ADDR);
                    end
                end
                HANDOFF: begin
                    if (bus.ag_done) begin
                        state      <= IDLE;
                        ag_start_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.ag_start  = ag_start_q;
    assign bus.busy      = busy_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_sys_o_wr.sv
// Bench for sys_o_wr: drives random result beats, predicts every DPR write
// into a queue and checks writes, gaps and the address-generator handoff.
module tb_sys_o_wr;
    import sys_o_pkg::*;

    localparam int FEATURE_BITS = FEATURE_BITS_D;
    localparam int DATA_W       = DATA_W_D;
    localparam int P            = P_D;
    localparam int M            = M_D;
    localparam int GAMMA        = GAMMA_D;
    localparam int AW           = 2 * FEATURE_BITS;
    localparam int N            = M * GAMMA;
    localparam int BEATS        = (N + P - 1) / P;
    localparam int EW           = AW + DATA_W;

    logic sys_clk = 1'b0;
    logic reset_n = 1'b0;

    sys_o_wr_if #(.FEATURE_BITS(FEATURE_BITS), .DATA_W(DATA_W), .P(P)) bus ();

    sys_o_wr #(
        .FEATURE_BITS(FEATURE_BITS), .DATA_W(DATA_W), .P(P), .M(M), .GAMMA(GAMMA)
    ) dut (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: pops the scoreboard, counts writes and holes inside a frame.
    int            wr_total   = 0;
    int            hole_total = 0;
    logic          prev_last  = 1'b0;
    logic [AW-1:0] last_addr  = AW'(N - 1);
    logic [EW-1:0] mon_e;

    always @(negedge sys_clk) begin
        if (prev_last) check("ag_start_rise", bus.ag_start, 1);
        prev_last = (bus.wr_en === 1'b1) && (bus.wr_addr == AW'(N - 1));
        if (bus.wr_en === 1'b1) begin
            wr_total++;
            last_addr = bus.wr_addr;
            if (exp_q.size() == 0) begin
                check("spurious_wr", bus.wr_en, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_word", {bus.wr_addr, bus.wr_data}, mon_e);
            end
        end else if (bus.busy === 1'b0) begin
            last_addr = AW'(N - 1);
        end else if (bus.busy === 1'b1 && last_addr != AW'(N - 1)) begin
            hole_total++;
        end
    end

    logic abort = 1'b0;

    task automatic send_beat(input logic [P*DATA_W-1:0] d, input int gap);
        int tries;
        if (gap > 0) begin
            bus.in_valid = 1'b0;
            tries = 0;
            while (bus.in_ready !== 1'b1 && tries < 50 && !abort) begin
                @(negedge sys_clk);
                tries++;
            end
            repeat (gap) @(negedge sys_clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tries = 0;
        while (bus.in_ready !== 1'b1 && tries < 50 && !abort) begin
            @(negedge sys_clk);
            tries++;
        end
        if (abort) return;
        if (tries >= 50) check("beat_accept_timeout", bus.in_ready, 1);
        @(negedge sys_clk);
    endtask

    task automatic watch(input bit fs_mid);
        int t;
        logic [AW-1:0] tgt;
        t   = 0;
        tgt = fs_mid ? AW'(10) : AW'(13);
        while (!(bus.wr_en === 1'b1 && bus.wr_addr == tgt) && t < 200) begin
            @(negedge sys_clk);
            t++;
        end
        if (t >= 200) begin
            check("watch_timeout", bus.wr_addr, tgt);
            return;
        end
        if (fs_mid) begin
            bus.frame_start = 1'b1;
            @(negedge sys_clk);
            bus.frame_start = 1'b0;
        end else begin
            reset_n = 1'b0;
            abort   = 1'b1;
            @(negedge sys_clk);
            check("rst_mid_wr_en", bus.wr_en, 0);
            check("rst_mid_busy", bus.busy, 0);
            reset_n = 1'b1;
            exp_q.delete();
        end
    endtask

    task automatic handoff(input int low);
        int t;
        int hi;
        t  = 0;
        hi = 0;
        while (bus.ag_start !== 1'b1 && t < 50) begin
            @(negedge sys_clk);
            t++;
        end
        if (t >= 50) check("ag_start_timeout", bus.ag_start, 1);
        repeat (low) begin
            if (bus.ag_start === 1'b1) hi++;
            @(negedge sys_clk);
        end
        bus.ag_done = 1'b1;
        if (bus.ag_start === 1'b1) hi++;
        @(negedge sys_clk);
        bus.ag_done = 1'b0;
        check("ag_start_cycles", hi, low + 1);
        check("ag_start_low", bus.ag_start, 0);
        check("busy_idle", bus.busy, 0);
        check("state_idle", bus.dbg_state, IDLE);
    endtask

    task automatic run_frame(input int gap_beat, input bit fs_mid, input bit rst_mid,
                             input bit ag_early, input int exp_holes);
        int w0;
        int h0;
        logic [P*DATA_W-1:0] d;
        abort = 1'b0;
        w0 = wr_total;
        h0 = hole_total;
        bus.frame_start = 1'b1;
        @(negedge sys_clk);
        bus.frame_start = 1'b0;
        bus.ag_done     = ag_early;
        fork
            begin
                for (int b = 0; b < BEATS && !abort; b++) begin
                    for (int k = 0; k < P; k++) d[k*DATA_W +: DATA_W] = DATA_W'($urandom);
                    for (int k = 0; k < P; k++)
                        if (b * P + k < N) exp_q.push_back({AW'(b * P + k), d[k*DATA_W +: DATA_W]});
                    send_beat(d, (b == gap_beat) ? 3 : 0);
                end
                bus.in_valid = 1'b0;
            end
            begin
                if (fs_mid || rst_mid) watch(fs_mid);
            end
        join
        bus.ag_done = 1'b0;
        if (!rst_mid) begin
            handoff(5);
            check("frame_writes", wr_total - w0, N);
            check("frame_holes", hole_total - h0, exp_holes);
            check("exp_q_empty", exp_q.size(), 0);
        end
    endtask

    initial begin
        int w0;
        bus.frame_start = 1'b0;
        bus.in_valid    = 1'b1;
        bus.in_data     = '1;
        bus.ag_done     = 1'b0;
        reset_n         = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_ag_start", bus.ag_start, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_state", bus.dbg_state, IDLE);
        reset_n      = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge sys_clk);

        run_frame(-1, 1'b0, 1'b0, 1'b0, 0);
        run_frame(3, 1'b0, 1'b0, 1'b1, 3);
        run_frame(-1, 1'b1, 1'b0, 1'b0, 0);

        run_frame(-1, 1'b0, 1'b1, 1'b0, 0);
        bus.in_valid = 1'b1;
        w0 = wr_total;
        repeat (10) @(negedge sys_clk);
        check("post_rst_writes", wr_total - w0, 0);
        check("post_rst_busy", bus.busy, 0);
        bus.in_valid = 1'b0;
        @(negedge sys_clk);

        run_frame(-1, 1'b0, 1'b0, 1'b0, 0);

        repeat (3) @(negedge sys_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miss_cnt);
        $fatal(1);
    end

endmodule
